// File: rtl/product_match_monitor.sv
// Scores (a, b, product) samples against a target over a programmable window.
// Optional product checker enabled by defining PRODUCT_CHECK_EN.
module product_match_monitor #(
    parameter int unsigned A_W   = 4,
    parameter int unsigned B_W   = 4,
    parameter int unsigned P_W   = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [P_W-1:0]   target,
    input  logic [CNT_W-1:0] window,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a_in,
    input  logic [B_W-1:0]   b_in,
    input  logic [P_W-1:0]   p_in,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] sample_count,
    output logic [A_W-1:0]   first_a,
    output logic [B_W-1:0]   first_b,
    output logic             chk_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [P_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0] window_q, window_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] sample_inc;
    logic             found_q, found_d;
    logic [A_W-1:0]   first_a_q, first_a_d;
    logic [B_W-1:0]   first_b_q, first_b_d;
    logic             handshake;
    logic             run_start;

    assign handshake  = in_valid && (state_q == StRun);
    assign run_start  = start && (state_q == StIdle);
    assign sample_inc = sample_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        window_d  = window_q;
        hit_d     = hit_q;
        sample_d  = sample_q;
        found_d   = found_q;
        first_a_d = first_a_q;
        first_b_d = first_b_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    target_d  = target;
                    window_d  = window;
                    hit_d     = '0;
                    sample_d  = '0;
                    found_d   = 1'b0;
                    first_a_d = '0;
                    first_b_d = '0;
                    state_d   = (window == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (handshake) begin
                    sample_d = sample_inc;
                    if (p_in == target_q) begin
                        hit_d = hit_q + CNT_W'(1);
                        if (!found_q) begin
                            found_d   = 1'b1;
                            first_a_d = a_in;
                            first_b_d = b_in;
                        end
                    end
                    if (sample_inc == window_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            target_q  <= '0;
            window_q  <= '0;
            hit_q     <= '0;
            sample_q  <= '0;
            found_q   <= 1'b0;
            first_a_q <= '0;
            first_b_q <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            window_q  <= window_d;
            hit_q     <= hit_d;
            sample_q  <= sample_d;
            found_q   <= found_d;
            first_a_q <= first_a_d;
            first_b_q <= first_b_d;
        end
    end

`ifdef PRODUCT_CHECK_EN
    logic [P_W-1:0] prod_chk;
    logic           err_q, err_d;

    assign prod_chk = P_W'(a_in) * P_W'(b_in);

    always_comb begin
        err_d = err_q;
        if (run_start) begin
            err_d = 1'b0;
        end else if (handshake && (prod_chk != p_in)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign chk_err = err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign in_ready     = (state_q == StRun);
    assign busy         = (state_q == StRun);
    assign done         = (state_q == StDone);
    assign found        = found_q;
    assign hit_count    = hit_q;
    assign sample_count = sample_q;
    assign first_a      = first_a_q;
    assign first_b      = first_b_q;

endmodule

// File: tb/tb_product_match_monitor.sv
// Scoreboard bench for product_match_monitor: per-sample counts and end-of-run results
// are queued when stimulus is driven and compared when the DUT reports them.
module tb_product_match_monitor;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  target, p_in;
    logic [15:0] window;
    logic [3:0]  a_in, b_in;
    logic        in_ready, busy, done, found, chk_err;
    logic [15:0] hit_count, sample_count;
    logic [3:0]  first_a, first_b;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic        found;
        logic [15:0] hits;
        logic [15:0] samples;
        logic [3:0]  fa;
        logic [3:0]  fb;
        logic        err;
    } res_t;

    typedef struct packed {
        logic [15:0] samples;
        logic [15:0] hits;
        logic        err;
    } cnt_t;

    res_t res_q[$];
    cnt_t cnt_q[$];

    logic [3:0] sa[16];
    logic [3:0] sb[16];
    logic [7:0] sp[16];

    always #5 clk = ~clk;

    product_match_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .target       (target),
        .window       (window),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .p_in         (p_in),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .hit_count    (hit_count),
        .sample_count (sample_count),
        .first_a      (first_a),
        .first_b      (first_b),
        .chk_err      (chk_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_ready"}, in_ready, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_found"}, found, 0);
        check_eq({tag, "_hits"}, hit_count, 0);
        check_eq({tag, "_samples"}, sample_count, 0);
        check_eq({tag, "_fa"}, first_a, 0);
        check_eq({tag, "_fb"}, first_b, 0);
        check_eq({tag, "_err"}, chk_err, 0);
    endtask

    // Drives one run; stall inserts two invalid cycles before the second sample.
    task automatic do_run(input logic [7:0] tgt, input logic [15:0] win, input int n,
                          input bit stall, input bit hold_start, input bit valid_idle);
        res_t r;
        cnt_t c;
        int   guard;
        r = '0;
        @(negedge clk);
        start = 1'b1; target = tgt; window = win; in_valid = valid_idle;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        if (win != 0) begin
            check_eq("busy_after_start", busy, 1);
            check_eq("err_cleared", chk_err, 0);
            check_eq("cnt_cleared", sample_count, 0);
        end
        for (int i = 0; i < n; i++) begin
            if (stall && i == 1) begin
                in_valid = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    check_eq("stall_samples", sample_count, 1);
                    check_eq("stall_done", done, 0);
                end
            end
            check_eq("ready_in_run", in_ready, 1);
            in_valid = 1'b1; a_in = sa[i]; b_in = sb[i]; p_in = sp[i];
            r.samples = r.samples + 16'd1;
            if (sp[i] == tgt) begin
                r.hits = r.hits + 16'd1;
                if (!r.found) begin
                    r.found = 1'b1; r.fa = sa[i]; r.fb = sb[i];
                end
            end
`ifdef PRODUCT_CHECK_EN
            if (sp[i] != 8'(sa[i]) * 8'(sb[i])) r.err = 1'b1;
`endif
            cnt_q.push_back('{samples: r.samples, hits: r.hits, err: r.err});
            @(negedge clk);
            c = cnt_q.pop_front();
            check_eq("sample_count", sample_count, c.samples);
            check_eq("hit_count", hit_count, c.hits);
            check_eq("chk_err_step", chk_err, c.err);
        end
        in_valid = 1'b0;
        start = 1'b0;
        res_q.push_back(r);
        guard = 0;
        while (!done && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check_eq("done_latency", guard, 0);
        check_eq("done_ready", in_ready, 0);
        r = res_q.pop_front();
        check_eq("res_found", found, r.found);
        check_eq("res_hits", hit_count, r.hits);
        check_eq("res_samples", sample_count, r.samples);
        check_eq("res_first_a", first_a, r.fa);
        check_eq("res_first_b", first_b, r.fb);
        check_eq("res_err", chk_err, r.err);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("hold_hits", hit_count, r.hits);
        check_eq("hold_found", found, r.found);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; target = '0; window = '0;
        a_in = '0; b_in = '0; p_in = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        // T1: reset in the middle of a run
        start = 1'b1; target = 8'd6; window = 16'd8;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; a_in = 4'd2; b_in = 4'd3; p_in = 8'd6;
        repeat (2) @(negedge clk);
        check_eq("t1_pre_hits", hit_count, 2);
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("t1_rst1");
        @(negedge clk);
        check_idle_zero("t1_rst2");
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("t1_no_done", done, 0);
            check_eq("t1_idle_busy", busy, 0);
        end

        // T2: basic hits
        sa[0] = 4'd3; sb[0] = 4'd5;  sp[0] = 8'd15;
        sa[1] = 4'd5; sb[1] = 4'd3;  sp[1] = 8'd15;
        sa[2] = 4'd2; sb[2] = 4'd7;  sp[2] = 8'd14;
        sa[3] = 4'd1; sb[3] = 4'd15; sp[3] = 8'd15;
        do_run(8'd15, 16'd4, 4, 1'b0, 1'b0, 1'b0);

        // T3: no hits over 16 samples
        for (int i = 0; i < 16; i++) begin
            sa[i] = 4'(i); sb[i] = 4'(i); sp[i] = 8'(i * i);
        end
        do_run(8'd143, 16'd16, 16, 1'b0, 1'b0, 1'b0);

        // T4: zero window, in_valid asserted but ignored
        do_run(8'd9, 16'd0, 0, 1'b0, 1'b0, 1'b1);

        // T5: stalls with start held high during the run
        sa[0] = 4'd7; sb[0] = 4'd9; sp[0] = 8'd63;
        sa[1] = 4'd9; sb[1] = 4'd7; sp[1] = 8'd63;
        do_run(8'd63, 16'd2, 2, 1'b1, 1'b1, 1'b0);

        // T6: inconsistent product still counts; chk_err only with the checker built in
        sa[0] = 4'd4; sb[0] = 4'd4; sp[0] = 8'd17;
        sa[1] = 4'd2; sb[1] = 4'd3; sp[1] = 8'd6;
        sa[2] = 4'd1; sb[2] = 4'd1; sp[2] = 8'd17;
        do_run(8'd17, 16'd3, 3, 1'b0, 1'b0, 1'b0);

        // Next run must clear the sticky error and the previous results
        sa[0] = 4'd6; sb[0] = 4'd2; sp[0] = 8'd12;
        do_run(8'd12, 16'd1, 1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
